// File: rtl/time_keeper.sv
// Wall-clock hh:mm:ss in BCD, advanced by a synchronised 1 Hz tick; supports time-set and
// an optional alarm compare (enabled by defining TIME_KEEPER_ALARM_EN).
module time_keeper #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_in,
  input  logic       hold,
  input  logic       set_en,
  input  logic [7:0] set_hh,
  input  logic [7:0] set_mm,
  output logic [7:0] hh_bcd,
  output logic [7:0] mm_bcd,
  output logic [7:0] ss_bcd,
  output logic       sec_pulse,
  output logic       min_rollover,
  output logic       hr_rollover,
  output logic       day_rollover,
  output logic       set_err,
  input  logic       alarm_arm,
  input  logic [7:0] alarm_hh,
  input  logic [7:0] alarm_mm,
  output logic       alarm_match
);

  localparam int ARM_CYCLES = SYNC_STAGES + 1;
  localparam int ARM_W      = $clog2(ARM_CYCLES);

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    return (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] max);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max);
  endfunction

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   samp_q, prev_q;
  logic                   armed_q;
  logic [ARM_W-1:0]       arm_cnt_q;
  logic [7:0]             hh_q, mm_q, ss_q;
  logic [7:0]             hh_d, mm_d, ss_d;
  logic [7:0]             hh_nx, mm_nx, ss_nx;
  logic                   sec_q, min_q, hr_q, day_q, set_err_q;
  logic                   adv, tick_adv, set_ok;
  logic                   ss_wrap, mm_wrap, hh_wrap;

  assign adv      = samp_q & ~prev_q & armed_q;
  assign tick_adv = adv & ~hold & ~set_en;
  assign set_ok   = bcd_ok(set_hh, 8'h23) && bcd_ok(set_mm, 8'h59);

  always_comb begin
    ss_wrap = (ss_q == 8'h59);
    mm_wrap = ss_wrap && (mm_q == 8'h59);
    hh_wrap = mm_wrap && (hh_q == 8'h23);
    ss_nx   = ss_wrap ? 8'h00 : bcd_inc(ss_q);
    mm_nx   = mm_q;
    hh_nx   = hh_q;
    if (ss_wrap) mm_nx = (mm_q == 8'h59) ? 8'h00 : bcd_inc(mm_q);
    if (mm_wrap) hh_nx = (hh_q == 8'h23) ? 8'h00 : bcd_inc(hh_q);
  end

  // A set request always owns the cycle; a coincident tick is dropped.
  always_comb begin
    hh_d = hh_q;
    mm_d = mm_q;
    ss_d = ss_q;
    if (set_en) begin
      if (set_ok) begin
        hh_d = set_hh;
        mm_d = set_mm;
        ss_d = 8'h00;
      end
    end else if (tick_adv) begin
      hh_d = hh_nx;
      mm_d = mm_nx;
      ss_d = ss_nx;
    end
  end

  // While disarmed, prev is held high so a tick already high at reset must fall before it counts.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q    <= '0;
      samp_q    <= 1'b0;
      prev_q    <= 1'b1;
      armed_q   <= 1'b0;
      arm_cnt_q <= '0;
      hh_q      <= 8'h00;
      mm_q      <= 8'h00;
      ss_q      <= 8'h00;
      sec_q     <= 1'b0;
      min_q     <= 1'b0;
      hr_q      <= 1'b0;
      day_q     <= 1'b0;
      set_err_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], tick_in};
      samp_q <= sync_q[SYNC_STAGES-1];
      prev_q <= armed_q ? samp_q : 1'b1;
      if (!armed_q) begin
        if (arm_cnt_q == ARM_W'(ARM_CYCLES - 1)) armed_q <= 1'b1;
        else arm_cnt_q <= arm_cnt_q + 1'b1;
      end
      hh_q      <= hh_d;
      mm_q      <= mm_d;
      ss_q      <= ss_d;
      sec_q     <= adv;
      min_q     <= tick_adv & ss_wrap;
      hr_q      <= tick_adv & mm_wrap;
      day_q     <= tick_adv & hh_wrap;
      set_err_q <= set_en & ~set_ok;
    end
  end

  assign hh_bcd       = hh_q;
  assign mm_bcd       = mm_q;
  assign ss_bcd       = ss_q;
  assign sec_pulse    = sec_q;
  assign min_rollover = min_q;
  assign hr_rollover  = hr_q;
  assign day_rollover = day_q;
  assign set_err      = set_err_q;

`ifdef TIME_KEEPER_ALARM_EN
  logic alarm_q, alarm_hit;

  assign alarm_hit = tick_adv && alarm_arm &&
                     bcd_ok(alarm_hh, 8'h23) && bcd_ok(alarm_mm, 8'h59) &&
                     (hh_nx == alarm_hh) && (mm_nx == alarm_mm) && (ss_nx == 8'h00);

  always_ff @(posedge clk) begin
    if (reset) alarm_q <= 1'b0;
    else       alarm_q <= alarm_hit;
  end

  assign alarm_match = alarm_q;
`else
  logic unused_alarm;
  assign unused_alarm = ^{alarm_arm, alarm_hh, alarm_mm};
  assign alarm_match  = 1'b0;
`endif

endmodule

// File: tb/tb_time_keeper.sv
// Directed bench for time_keeper: reset/arming, tick latency, BCD carries, set, hold, alarm.
module tb_time_keeper;
  logic       clk = 1'b0;
  logic       reset, tick_in, hold, set_en, alarm_arm;
  logic [7:0] set_hh, set_mm, alarm_hh, alarm_mm;
  logic [7:0] hh_bcd, mm_bcd, ss_bcd;
  logic       sec_pulse, min_rollover, hr_rollover, day_rollover, set_err, alarm_match;

  int n_vec = 0;
  int n_err = 0;
  int n_sec = 0, n_min = 0, n_hr = 0, n_day = 0, n_alarm = 0, n_alarm_nosec = 0;
  logic [23:0] alarm_at = '0;

  time_keeper #(.SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .tick_in(tick_in), .hold(hold), .set_en(set_en),
    .set_hh(set_hh), .set_mm(set_mm), .hh_bcd(hh_bcd), .mm_bcd(mm_bcd), .ss_bcd(ss_bcd),
    .sec_pulse(sec_pulse), .min_rollover(min_rollover), .hr_rollover(hr_rollover),
    .day_rollover(day_rollover), .set_err(set_err), .alarm_arm(alarm_arm),
    .alarm_hh(alarm_hh), .alarm_mm(alarm_mm), .alarm_match(alarm_match)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sec_pulse)    n_sec++;
    if (min_rollover) n_min++;
    if (hr_rollover)  n_hr++;
    if (day_rollover) n_day++;
    if (alarm_match) begin
      n_alarm++;
      alarm_at = {hh_bcd, mm_bcd, ss_bcd};
      if (!sec_pulse) n_alarm_nosec++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    tick_in = 1'b1;
    repeat (8) step();
    tick_in = 1'b0;
    repeat (8) step();
  endtask

  task automatic do_set(input logic [7:0] h, input logic [7:0] m);
    set_hh = h;
    set_mm = m;
    set_en = 1'b1;
    step();
    set_en = 1'b0;
  endtask

  task automatic check_time(input string name, input logic [23:0] exp);
    n_vec++;
    if ({hh_bcd, mm_bcd, ss_bcd} !== exp) begin
      n_err++;
      $display("FAIL %s: got %06h expected %06h", name, {hh_bcd, mm_bcd, ss_bcd}, exp);
    end
  endtask

  task automatic test_reset();
    int base;
    reset = 1'b1; tick_in = 1'b1; hold = 1'b0; set_en = 1'b0;
    set_hh = 8'h00; set_mm = 8'h00; alarm_arm = 1'b0; alarm_hh = 8'h00; alarm_mm = 8'h00;
    repeat (3) step();
    reset = 1'b0;
    base = n_sec;
    repeat (10) step();
    check_time("reset_time", 24'h000000);
    n_vec++;
    if ((n_sec - base) !== 0) begin
      n_err++;
      $display("FAIL reset_no_pulse: got %0d sec_pulses expected 0", n_sec - base);
    end
    n_vec++;
    if ({sec_pulse, min_rollover, hr_rollover, day_rollover, set_err, alarm_match} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_pulses: got %06b expected 000000",
               {sec_pulse, min_rollover, hr_rollover, day_rollover, set_err, alarm_match});
    end
    tick_in = 1'b0;
    repeat (8) step();
  endtask

  task automatic test_count();
    for (int i = 0; i < 3; i++) begin
      tick_in = 1'b1;
      repeat (3) step();
      n_vec++;
      if (sec_pulse !== 1'b0) begin
        n_err++;
        $display("FAIL count_early_%0d: sec_pulse=%b expected 0", i, sec_pulse);
      end
      step();
      n_vec++;
      if (sec_pulse !== 1'b1) begin
        n_err++;
        $display("FAIL count_latency_%0d: sec_pulse=%b expected 1", i, sec_pulse);
      end
      step();
      n_vec++;
      if (sec_pulse !== 1'b0) begin
        n_err++;
        $display("FAIL count_width_%0d: sec_pulse=%b expected 0", i, sec_pulse);
      end
      repeat (3) step();
      tick_in = 1'b0;
      repeat (8) step();
    end
    check_time("count_3", 24'h000003);
  endtask

  task automatic test_day_rollover();
    do_set(8'h23, 8'h59);
    check_time("set_2359", 24'h235900);
    repeat (59) tick();
    check_time("at_235959", 24'h235959);
    tick_in = 1'b1;
    repeat (4) step();
    n_vec++;
    if ({sec_pulse, min_rollover, hr_rollover, day_rollover} !== 4'b1111) begin
      n_err++;
      $display("FAIL day_pulses: got %04b expected 1111",
               {sec_pulse, min_rollover, hr_rollover, day_rollover});
    end
    check_time("day_wrap", 24'h000000);
    repeat (4) step();
    tick_in = 1'b0;
    repeat (8) step();
  endtask

  task automatic test_set_err();
    int bm, bh, bd;
    do_set(8'h24, 8'h00);
    n_vec++;
    if (set_err !== 1'b1) begin
      n_err++;
      $display("FAIL set_err_hh: set_err=%b expected 1", set_err);
    end
    check_time("set_err_hh_time", 24'h000000);
    step();
    n_vec++;
    if (set_err !== 1'b0) begin
      n_err++;
      $display("FAIL set_err_width: set_err=%b expected 0", set_err);
    end
    do_set(8'h00, 8'h5A);
    n_vec++;
    if (set_err !== 1'b1) begin
      n_err++;
      $display("FAIL set_err_mm: set_err=%b expected 1", set_err);
    end
    check_time("set_err_mm_time", 24'h000000);
    step();
    do_set(8'h09, 8'h59);
    n_vec++;
    if (set_err !== 1'b0) begin
      n_err++;
      $display("FAIL set_ok_no_err: set_err=%b expected 0", set_err);
    end
    bm = n_min; bh = n_hr; bd = n_day;
    repeat (60) tick();
    check_time("carry_0959", 24'h100000);
    n_vec++;
    if ({n_min - bm, n_hr - bh, n_day - bd} !== {32'd1, 32'd1, 32'd0}) begin
      n_err++;
      $display("FAIL carry_rollovers: got min=%0d hr=%0d day=%0d expected 1 1 0",
               n_min - bm, n_hr - bh, n_day - bd);
    end
  endtask

  task automatic test_hold();
    int bs, bm;
    bs = n_sec; bm = n_min;
    hold = 1'b1;
    repeat (5) tick();
    hold = 1'b0;
    n_vec++;
    if ((n_sec - bs) !== 5) begin
      n_err++;
      $display("FAIL hold_pulses: got %0d expected 5", n_sec - bs);
    end
    n_vec++;
    if ((n_min - bm) !== 0) begin
      n_err++;
      $display("FAIL hold_rollover: got %0d expected 0", n_min - bm);
    end
    check_time("hold_frozen", 24'h100000);
  endtask

  task automatic test_set_coincident();
    tick();
    check_time("pre_coincident", 24'h100001);
    tick_in = 1'b1;
    repeat (3) step();
    set_hh = 8'h12; set_mm = 8'h34; set_en = 1'b1;
    step();
    set_en = 1'b0;
    n_vec++;
    if (sec_pulse !== 1'b1) begin
      n_err++;
      $display("FAIL coincident_pulse: sec_pulse=%b expected 1", sec_pulse);
    end
    check_time("coincident_load", 24'h123400);
    repeat (3) step();
    tick_in = 1'b0;
    repeat (8) step();
    check_time("coincident_after", 24'h123400);
  endtask

  task automatic test_reset_mid();
    int bs;
    tick_in = 1'b1;
    repeat (3) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    bs = n_sec;
    check_time("mid_reset_time", 24'h000000);
    repeat (12) step();
    tick_in = 1'b0;
    repeat (8) step();
    n_vec++;
    if ((n_sec - bs) !== 0) begin
      n_err++;
      $display("FAIL mid_reset_pulse: got %0d expected 0", n_sec - bs);
    end
    tick();
    check_time("mid_reset_rearmed", 24'h000001);
  endtask

  task automatic test_alarm();
    int ba, exp_n;
`ifdef TIME_KEEPER_ALARM_EN
    exp_n = 1;
`else
    exp_n = 0;
`endif
    alarm_hh = 8'h07; alarm_mm = 8'h30; alarm_arm = 1'b1;
    ba = n_alarm;
    do_set(8'h07, 8'h30);
    repeat (3) step();
    n_vec++;
    if ((n_alarm - ba) !== 0) begin
      n_err++;
      $display("FAIL alarm_on_set: got %0d expected 0", n_alarm - ba);
    end
    do_set(8'h07, 8'h29);
    ba = n_alarm;
    repeat (60) tick();
    check_time("alarm_time", 24'h073000);
    n_vec++;
    if ((n_alarm - ba) !== exp_n) begin
      n_err++;
      $display("FAIL alarm_armed: got %0d expected %0d", n_alarm - ba, exp_n);
    end
    if (exp_n == 1) begin
      n_vec++;
      if (alarm_at !== 24'h073000 || n_alarm_nosec !== 0) begin
        n_err++;
        $display("FAIL alarm_when: at %06h nosec=%0d expected 073000 0", alarm_at, n_alarm_nosec);
      end
    end
    alarm_arm = 1'b0;
    do_set(8'h07, 8'h29);
    ba = n_alarm;
    repeat (60) tick();
    n_vec++;
    if ((n_alarm - ba) !== 0) begin
      n_err++;
      $display("FAIL alarm_disarmed: got %0d expected 0", n_alarm - ba);
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_day_rollover();
    test_set_err();
    test_hold();
    test_set_coincident();
    test_reset_mid();
    test_alarm();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
